axi_burst_read_slave: RTL and testbench

- AXI4 read-only slave that serves the 4-beat INCR line-fill bursts issued by the L1 instruction cache through the CPU wrapper and bus.
- Sits between the AXI read channels (AR/R) and a synchronous instruction SRAM with 1-cycle read latency.
- Sustains one R beat per cycle and handles arbitrary RREADY back-pressure without a data buffer, by holding the SRAM address.
- Returns SLVERR/DECERR for unsupported or out-of-range requests.

---
 rtl/axi_pkg.sv | 17 +
 rtl/axi_rd_addr_gen.sv | 19 +
 rtl/axi_burst_read_slave.sv | 134 +++++++++++++
 tb/tb_axi_burst_read_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-slave FSM state type.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// SRAM word address for the current (or, on advance, the next) beat of an INCR burst.
// Only the low 10 word-address bits count, so a burst wraps inside its 4 KB page.
module axi_rd_addr_gen #(
  parameter int SRAM_AW = 14
) (
  input  logic [SRAM_AW-1:0] i_start_word,
  input  logic [3:0]         i_beat,
  input  logic               i_advance,
  output logic [SRAM_AW-1:0] o_sram_a
);

  localparam int PAGE_W = 10;

  logic [PAGE_W-1:0] w_page_off;

  assign w_page_off = i_start_word[PAGE_W-1:0] + PAGE_W'(i_beat) + PAGE_W'(i_advance);
  assign o_sram_a   = {i_start_word[SRAM_AW-1:PAGE_W], w_page_off};

endmodule

// File: rtl/axi_burst_read_slave.sv
// AXI4 read-only slave serving INCR line-fill bursts from a 1-cycle-latency SRAM.
// Back-pressure is absorbed by holding the SRAM address, so no data buffer is needed.
module axi_burst_read_slave
  import axi_pkg::*;
#(
  parameter int                 ID_W    = 8,
  parameter int                 ADDR_W  = 32,
  parameter int                 DATA_W  = 32,
  parameter int                 SRAM_AW = 14,
  parameter logic [ADDR_W-1:0]  BASE    = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ID_W-1:0]    ARID_S,
  input  logic [ADDR_W-1:0]  ARADDR_S,
  input  logic [3:0]         ARLEN_S,
  input  logic [2:0]         ARSIZE_S,
  input  logic [1:0]         ARBURST_S,
  input  logic               ARVALID_S,
  output logic               ARREADY_S,
  output logic [ID_W-1:0]    RID_S,
  output logic [DATA_W-1:0]  RDATA_S,
  output logic [1:0]         RRESP_S,
  output logic               RLAST_S,
  output logic               RVALID_S,
  input  logic               RREADY_S,
  output logic               sram_cs,
  output logic               sram_oe,
  output logic [SRAM_AW-1:0] sram_a,
  input  logic [DATA_W-1:0]  sram_do
);

  state_e             r_state, w_next;
  logic [ID_W-1:0]    r_id;
  logic [SRAM_AW-1:0] r_word;
  logic [3:0]         r_len;
  logic [3:0]         r_cnt;
  logic [1:0]         r_resp;

  logic               w_ar_hs, w_r_hs, w_last, w_ok;
  logic [1:0]         w_resp;
  logic [SRAM_AW-1:0] w_gen_a;
  logic [1:0]         w_unused_addr;

  assign w_unused_addr = ARADDR_S[1:0];

  // Handshake is derived from state, not RVALID_S, to keep the address path loop-free.
  assign w_ar_hs = ARVALID_S & (r_state == IDLE);
  assign w_r_hs  = RREADY_S & (r_state == DATA);
  assign w_last  = (r_cnt == r_len);
  assign w_ok    = (r_resp == RESP_OKAY);

  always_comb begin
    w_resp = RESP_OKAY;
    if (ARADDR_S[ADDR_W-1:SRAM_AW+2] != BASE[ADDR_W-1:SRAM_AW+2])
      w_resp = RESP_DECERR;
    else if (ARBURST_S != BURST_INCR || ARSIZE_S != SIZE_WORD)
      w_resp = RESP_SLVERR;
  end

  axi_rd_addr_gen #(.SRAM_AW(SRAM_AW)) u_addr_gen (
    .i_start_word (r_word),
    .i_beat       (r_cnt),
    .i_advance    (w_r_hs & ~w_last),
    .o_sram_a     (w_gen_a)
  );

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ar_hs) w_next = ADDR;
      ADDR:    w_next = DATA;
      DATA:    if (w_r_hs && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id   <= '0;
      r_word <= '0;
      r_len  <= '0;
      r_resp <= RESP_OKAY;
      r_cnt  <= '0;
    end else if (w_ar_hs) begin
      r_id   <= ARID_S;
      r_word <= ARADDR_S[SRAM_AW+1:2];
      r_len  <= ARLEN_S;
      r_resp <= w_resp;
      r_cnt  <= '0;
    end else if (w_r_hs && !w_last) begin
      r_cnt  <= r_cnt + 4'd1;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    ARREADY_S = 1'b0;
    RVALID_S  = 1'b0;
    RLAST_S   = 1'b0;
    RRESP_S   = RESP_OKAY;
    RID_S     = '0;
    RDATA_S   = '0;
    sram_cs   = 1'b0;
    sram_oe   = 1'b0;
    sram_a    = '0;
    case (r_state)
      IDLE: ARREADY_S = 1'b1;
      ADDR: begin
        sram_cs = w_ok;
        sram_oe = w_ok;
        sram_a  = w_gen_a;
      end
      DATA: begin
        RVALID_S = 1'b1;
        RLAST_S  = w_last;
        RRESP_S  = r_resp;
        RID_S    = r_id;
        RDATA_S  = w_ok ? sram_do : '0;
        sram_cs  = w_ok;
        sram_oe  = w_ok;
        sram_a   = w_gen_a;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_read_slave.sv
// Scoreboard bench for axi_burst_read_slave: stimulus pushes expected beats, a monitor checks R.
module tb_axi_burst_read_slave;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S;
  logic        sram_cs;
  logic        sram_oe;
  logic [13:0] sram_a;
  logic [31:0] sram_do;

  axi_burst_read_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ARID_S    (ARID_S),
    .ARADDR_S  (ARADDR_S),
    .ARLEN_S   (ARLEN_S),
    .ARSIZE_S  (ARSIZE_S),
    .ARBURST_S (ARBURST_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .sram_cs   (sram_cs),
    .sram_oe   (sram_oe),
    .sram_a    (sram_a),
    .sram_do   (sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents: word w holds 0xC0DE_0000 | w.
  logic [31:0] mem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE_0000 | i;
    sram_do = '0;
  end
  always @(posedge clk) if (sram_cs && sram_oe) sram_do <= mem[sram_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [13:0] word;
    logic [13:0] nxt;
    logic        first;
  } beat_t;

  beat_t sb[$];
  int    last_hs_edge  = 0;
  int    first_hs_edge = 0;

  task automatic push_burst(input logic [7:0] id, input logic [1:0] resp, input int n,
                            input logic [13:0] w0, input logic [13:0] w1,
                            input logic [13:0] w2, input logic [13:0] w3);
    logic [13:0] w[4];
    beat_t e;
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < n; i++) begin
      e.id    = id;
      e.resp  = resp;
      e.data  = (resp == 2'd0) ? mem[w[i]] : 32'h0;
      e.last  = (i == n - 1);
      e.word  = w[i];
      e.nxt   = (i < 3) ? w[i+1] : w[i];
      e.first = (i == 0);
      sb.push_back(e);
    end
  endtask

  // Monitor: compares every valid R cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && RVALID_S) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(RVALID_S), 32'd0);
      end else begin
        beat_t e;
        e = sb[0];
        check("rid",     32'(RID_S),   32'(e.id));
        check("rdata",   RDATA_S,      e.data);
        check("rresp",   32'(RRESP_S), 32'(e.resp));
        check("rlast",   32'(RLAST_S), 32'(e.last));
        check("sram_cs", 32'(sram_cs), 32'(e.resp == 2'd0));
        if (e.resp == 2'd0)
          check("sram_a", 32'(sram_a), 32'((RREADY_S && !e.last) ? e.nxt : e.word));
        if (RREADY_S) begin
          void'(sb.pop_front());
          last_hs_edge = cyc + 1;
          if (e.first) first_hs_edge = cyc + 1;
        end
      end
    end
  end

  task automatic issue_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit hold,
                          output int ar_edge);
    bit ok;
    ARID_S    = id;
    ARADDR_S  = addr;
    ARLEN_S   = len;
    ARSIZE_S  = size;
    ARBURST_S = burst;
    ARVALID_S = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ARREADY_S) begin
        ok = 1'b1;
        break;
      end
    end
    check("ar_accept", 32'(ok), 32'd1);
    ar_edge = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) ARVALID_S = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int n_edge, n2_edge;

  initial begin
    rst_n     = 1'b0;
    RREADY_S  = 1'b1;
    ARVALID_S = 1'b0;
    ARID_S    = '0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARSIZE_S  = 3'b010;
    ARBURST_S = 2'b01;
    #12;
    check("rst_arready", 32'(ARREADY_S), 32'd1);
    check("rst_rvalid",  32'(RVALID_S),  32'd0);
    check("rst_rlast",   32'(RLAST_S),   32'd0);
    check("rst_rresp",   32'(RRESP_S),   32'd0);
    check("rst_rid",     32'(RID_S),     32'd0);
    check("rst_rdata",   RDATA_S,        32'd0);
    check("rst_cs",      32'(sram_cs),   32'd0);
    check("rst_oe",      32'(sram_oe),   32'd0);
    check("rst_sram_a",  32'(sram_a),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic 4-beat burst, RREADY high
    push_burst(8'h15, 2'd0, 4, 14'h10, 14'h11, 14'h12, 14'h13);
    issue_ar(8'h15, 32'h0001_0040, 4'd3, 3'b010, 2'b01, 1'b0, n_edge);
    drain();
    check("t1_first_latency", 32'(first_hs_edge - n_edge), 32'd2);
    check("t1_last_latency",  32'(last_hs_edge - n_edge),  32'd5);

    // 2: back-pressure on beat 2 for 3 cycles
    push_burst(8'h15, 2'd0, 4, 14'h10, 14'h11, 14'h12, 14'h13);
    issue_ar(8'h15, 32'h0001_0040, 4'd3, 3'b010, 2'b01, 1'b0, n_edge);
    @(posedge clk);
    @(posedge clk);
    #1;
    RREADY_S = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_rvalid", 32'(RVALID_S), 32'd1);
      check("t2_stall_rdata",  RDATA_S,       32'hC0DE_0011);
      check("t2_stall_sram_a", 32'(sram_a),   32'h11);
      @(posedge clk);
    end
    #1;
    RREADY_S = 1'b1;
    drain();

    // 3: decode miss then unsupported burst type
    push_burst(8'h31, 2'd3, 4, 14'h0, 14'h0, 14'h0, 14'h0);
    issue_ar(8'h31, 32'h0002_0000, 4'd3, 3'b010, 2'b01, 1'b0, n_edge);
    drain();
    push_burst(8'h32, 2'd2, 4, 14'h0, 14'h0, 14'h0, 14'h0);
    issue_ar(8'h32, 32'h0001_0100, 4'd3, 3'b010, 2'b00, 1'b0, n_edge);
    drain();

    // 4: 4 KB page wrap
    push_burst(8'h44, 2'd0, 4, 14'h3FE, 14'h3FF, 14'h000, 14'h001);
    issue_ar(8'h44, 32'h0001_0FF8, 4'd3, 3'b010, 2'b01, 1'b0, n_edge);
    drain();

    // 5: back-to-back ARs with ARVALID held high
    push_burst(8'h21, 2'd0, 1, 14'h80, 14'h0, 14'h0, 14'h0);
    push_burst(8'h22, 2'd0, 4, 14'hC0, 14'hC1, 14'hC2, 14'hC3);
    issue_ar(8'h21, 32'h0001_0200, 4'd0, 3'b010, 2'b01, 1'b1, n_edge);
    issue_ar(8'h22, 32'h0001_0300, 4'd3, 3'b010, 2'b01, 1'b0, n2_edge);
    check("t5_gap_after_rlast", 32'(n2_edge - last_hs_edge), 32'd1);
    check("t5_ar_spacing",      32'(n2_edge - n_edge),       32'd3);
    drain();

    // 6: reset during beat 2
    push_burst(8'h66, 2'd0, 4, 14'h10, 14'h11, 14'h12, 14'h13);
    issue_ar(8'h66, 32'h0001_0040, 4'd3, 3'b010, 2'b01, 1'b0, n_edge);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rvalid",  32'(RVALID_S),  32'd0);
    check("t6_rst_cs",      32'(sram_cs),   32'd0);
    check("t6_rst_rlast",   32'(RLAST_S),   32'd0);
    check("t6_rst_arready", 32'(ARREADY_S), 32'd1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_post_arready", 32'(ARREADY_S), 32'd1);
    @(posedge clk);
    #1;
    push_burst(8'h67, 2'd0, 4, 14'h10, 14'h11, 14'h12, 14'h13);
    issue_ar(8'h67, 32'h0001_0040, 4'd3, 3'b010, 2'b01, 1'b0, n_edge);
    drain();
    check("t6_first_latency", 32'(first_hs_edge - n_edge), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
